// File: rtl/spart_key_capture.sv
// spart_key_capture
// Serial key-state receiver. A UART frame on rxd carries one ASCII byte.
// Recognised bytes set or clear bits of a five-bit key vector (W A S D space).
// Each accepted byte gives a one-cycle SPART_we strobe together with the
// updated SPART_keys value.
//
// Build option: define SPART_PARITY_EN to receive 8E1 frames. A ninth
// (parity) bit is then sampled and checked. The default build receives 8N1.
//
// Timing: the FSM samples every bit when the baud counter reaches 1, so a
// load of N gives a sample N cycles later. The start bit loads half a bit
// time, so every later sample falls near the middle of its bit.

module spart_key_capture #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rxd,
   output logic       SPART_we,
   output logic [4:0] SPART_keys,
   output logic       frame_err,
   output logic       rx_busy
);

   localparam logic [11:0] FULL_BIT = 12'(CLKS_PER_BIT);
   localparam logic [11:0] HALF_BIT = 12'(CLKS_PER_BIT / 2);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef SPART_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } state_t;

   // Returns {hit, new_keys}. An unrecognised byte gives hit = 0 and leaves
   // the keys unchanged.
   function automatic logic [5:0] decode_key(input logic [7:0] b, input logic [4:0] k);
      logic [5:0] r;
      r = {1'b0, k};
      case (b)
         8'h77:   r = {1'b1, k | 5'b00001};
         8'h61:   r = {1'b1, k | 5'b00010};
         8'h73:   r = {1'b1, k | 5'b00100};
         8'h64:   r = {1'b1, k | 5'b01000};
         8'h20:   r = {1'b1, k | 5'b10000};
         8'h57:   r = {1'b1, k & 5'b11110};
         8'h41:   r = {1'b1, k & 5'b11101};
         8'h53:   r = {1'b1, k & 5'b11011};
         8'h44:   r = {1'b1, k & 5'b10111};
         8'h5F:   r = {1'b1, k & 5'b01111};
         8'h1B:   r = {1'b1, 5'b00000};
         default: r = {1'b0, k};
      endcase
      return r;
   endfunction

`ifdef SPART_PARITY_EN
   // Even parity: the data bits and the parity bit together hold an even
   // number of ones.
   function automatic logic parity_ok(input logic [7:0] d, input logic p);
      return ~(^{d, p});
   endfunction
`endif

   // Synchronizer and edge-detect flops.
   logic sync1_q, sync2_q, rxd_prev_q;

   // FSM and datapath registers.
   state_t      state_q, state_d;
   logic [11:0] baud_q, baud_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [7:0]  shift_q, shift_d;
   logic        hold_q, hold_d;     // bad stop bit: wait in STOP for line high
   logic [4:0]  keys_q, keys_d;
   logic        we_q, we_d;
   logic        err_q, err_d;
   logic        busy_q, busy_d;
`ifdef SPART_PARITY_EN
   logic        par_q, par_d;
`endif

   logic        rxd_s;
   logic        fall_s;
   logic        tick_s;
   logic        frame_ok_s;
   logic [5:0]  dec_s;

   assign rxd_s  = sync2_q;
   assign fall_s = rxd_prev_q & ~sync2_q;
   assign tick_s = (baud_q == 12'd1);
   assign dec_s  = decode_key(shift_q, keys_q);
`ifdef SPART_PARITY_EN
   assign frame_ok_s = parity_ok(shift_q, par_q);
`else
   assign frame_ok_s = 1'b1;
`endif

   // Bring rxd into the clk domain and keep the previous value for edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         rxd_prev_q <= 1'b1;
      end else begin
         sync1_q    <= rxd;
         sync2_q    <= sync1_q;
         rxd_prev_q <= sync2_q;
      end
   end

   // Next state: frame sequencing, bit sampling, key decode and the output pulses.
   always_comb begin
      state_d   = state_q;
      baud_d    = baud_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      hold_d    = hold_q;
      keys_d    = keys_q;
      we_d      = 1'b0;
      err_d     = 1'b0;
`ifdef SPART_PARITY_EN
      par_d     = par_q;
`endif
      case (state_q)
         ST_IDLE: begin
            hold_d = 1'b0;
            if (fall_s) begin
               state_d   = ST_START;
               bit_cnt_d = 3'd0;
               baud_d    = HALF_BIT;
            end else begin
               baud_d    = 12'd0;
            end
         end
         ST_START: begin
            if (tick_s) begin
               if (!rxd_s) begin
                  state_d = ST_DATA;
                  baud_d  = FULL_BIT;
               end else begin
                  state_d = ST_IDLE;    // glitch: drop it silently
                  baud_d  = 12'd0;
               end
            end else begin
               baud_d = baud_q - 12'd1;
            end
         end
         ST_DATA: begin
            if (tick_s) begin
               shift_d = {rxd_s, shift_q[7:1]};
               baud_d  = FULL_BIT;
               if (bit_cnt_q == 3'd7) begin
                  bit_cnt_d = 3'd0;
`ifdef SPART_PARITY_EN
                  state_d   = ST_PARITY;
`else
                  state_d   = ST_STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end else begin
               baud_d = baud_q - 12'd1;
            end
         end
`ifdef SPART_PARITY_EN
         ST_PARITY: begin
            if (tick_s) begin
               par_d   = rxd_s;
               baud_d  = FULL_BIT;
               state_d = ST_STOP;
            end else begin
               baud_d = baud_q - 12'd1;
            end
         end
`endif
         ST_STOP: begin
            if (hold_q) begin
               if (rxd_s) begin
                  state_d = ST_IDLE;
                  hold_d  = 1'b0;
               end else begin
                  state_d = ST_STOP;
               end
            end else if (tick_s) begin
               baud_d = 12'd0;
               if (!rxd_s) begin
                  err_d  = 1'b1;        // framing error: discard the byte, wait for idle line
                  hold_d = 1'b1;
               end else if (!frame_ok_s) begin
                  err_d   = 1'b1;       // parity error: discard the byte
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_IDLE;
                  if (dec_s[5]) begin
                     keys_d = dec_s[4:0];
                     we_d   = 1'b1;
                  end else begin
                     keys_d = keys_q;
                  end
               end
            end else begin
               baud_d = baud_q - 12'd1;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            baud_d    = 12'd0;
            bit_cnt_d = 3'd0;
            hold_d    = 1'b0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers. All outputs are driven straight from flops.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         baud_q    <= 12'd0;
         bit_cnt_q <= 3'd0;
         shift_q   <= 8'd0;
         hold_q    <= 1'b0;
         keys_q    <= 5'd0;
         we_q      <= 1'b0;
         err_q     <= 1'b0;
         busy_q    <= 1'b0;
`ifdef SPART_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         baud_q    <= baud_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         hold_q    <= hold_d;
         keys_q    <= keys_d;
         we_q      <= we_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
`ifdef SPART_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

   assign SPART_we   = we_q;
   assign SPART_keys = keys_q;
   assign frame_err  = err_q;
   assign rx_busy    = busy_q;

endmodule

// File: tb/tb_spart_key_capture.sv
// Bench for spart_key_capture with CLKS_PER_BIT = 8. Each task queues the key
// vectors it expects before driving a frame. A negedge monitor records every
// SPART_we strobe, and the task then pops the queues and compares them.
module tb_spart_key_capture;

   localparam int CPB = 8;
`ifdef SPART_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       rxd   = 1'b1;
   logic       SPART_we;
   logic [4:0] SPART_keys;
   logic       frame_err;
   logic       rx_busy;

   int vectors     = 0;
   int miscompares = 0;

   logic [4:0] exp_q[$];
   logic [4:0] obs_q[$];
   int         err_pulses   = 0;
   int         err_cycles   = 0;
   int         overlap_viol = 0;
   int         stable_viol  = 0;
   logic [4:0] prev_keys    = 5'd0;
   logic       prev_err     = 1'b0;

   spart_key_capture #(.CLKS_PER_BIT(CPB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rxd       (rxd),
      .SPART_we  (SPART_we),
      .SPART_keys(SPART_keys),
      .frame_err (frame_err),
      .rx_busy   (rx_busy)
   );

   always #5 clk = ~clk;

   // Monitor: record strobes, count error pulses and flag output-rule violations.
   always @(negedge clk) begin
      if (SPART_we === 1'b1) obs_q.push_back(SPART_keys);
      if (frame_err === 1'b1) err_cycles <= err_cycles + 1;
      if (frame_err === 1'b1 && prev_err !== 1'b1) err_pulses <= err_pulses + 1;
      if (frame_err === 1'b1 && SPART_we === 1'b1) overlap_viol <= overlap_viol + 1;
      if (rst_n === 1'b1 && SPART_we !== 1'b1 && SPART_keys !== prev_keys)
         stable_viol <= stable_viol + 1;
      prev_keys <= SPART_keys;
      prev_err  <= frame_err;
   end

   function automatic logic epar(input logic [7:0] d);
      return ^d;
   endfunction

   // Drive one full frame, LSB first. The caller is aligned to a negedge.
   task automatic send_byte(input logic [7:0] d, input logic stop_bit, input logic par_bit);
      logic [10:0] frame;
`ifdef SPART_PARITY_EN
      frame = {stop_bit, par_bit, d, 1'b0};
`else
      frame = {par_bit, stop_bit, d, 1'b0};
`endif
      for (int i = 0; i < FRAME_BITS; i++) begin
         rxd = frame[i];
         repeat (CPB) @(negedge clk);
      end
      rxd = 1'b1;
   endtask

   task automatic send_key(input logic [7:0] d, input logic [4:0] exp_keys);
      exp_q.push_back(exp_keys);
      send_byte(d, 1'b1, epar(d));
   endtask

   task automatic test_reset;
      @(negedge clk);
      vectors++; if (SPART_we !== 1'b0) begin miscompares++; $display("FAIL reset_we: got %b expected 0", SPART_we); end
      vectors++; if (SPART_keys !== 5'b00000) begin miscompares++; $display("FAIL reset_keys: got %b expected 00000", SPART_keys); end
      vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_err: got %b expected 0", frame_err); end
      vectors++; if (rx_busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", rx_busy); end
      rst_n = 1'b1;
      repeat (2 * CPB) @(negedge clk);
   endtask

   task automatic test_set_keys;
      logic [4:0] e, o;
      send_key(8'h77, 5'b00001);
      send_key(8'h64, 5'b01001);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 5'bxxxxx;
         vectors++; if (o !== e) begin miscompares++; $display("FAIL set_keys: got %b expected %b", o, e); end
      end
      vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL set_keys_extra: got %0d extra strobes expected 0", obs_q.size()); end
      obs_q.delete();
   endtask

   task automatic test_back_to_back;
      logic [4:0] e, o;
      send_key(8'h61, 5'b01011);
      send_key(8'h73, 5'b01111);
      send_key(8'h20, 5'b11111);
      send_key(8'h5F, 5'b01111);
      send_key(8'h1B, 5'b00000);
      send_key(8'h77, 5'b00001);
      send_key(8'h57, 5'b00000);
      send_key(8'h1B, 5'b00000);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 5'bxxxxx;
         vectors++; if (o !== e) begin miscompares++; $display("FAIL back_to_back: got %b expected %b", o, e); end
      end
      vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL b2b_extra: got %0d extra strobes expected 0", obs_q.size()); end
      obs_q.delete();
      vectors++; if (SPART_keys !== 5'b00000) begin miscompares++; $display("FAIL b2b_final: got %b expected 00000", SPART_keys); end
   endtask

   task automatic test_ignore;
      int e0;
      logic [4:0] e, o;
      send_key(8'h73, 5'b00100);
      e0 = err_pulses;
      send_byte(8'h42, 1'b1, epar(8'h42));
      repeat (CPB) @(negedge clk);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 5'bxxxxx;
         vectors++; if (o !== e) begin miscompares++; $display("FAIL ignore_pre: got %b expected %b", o, e); end
      end
      vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL ignore_strobe: got %0d strobes expected 0", obs_q.size()); end
      obs_q.delete();
      vectors++; if (SPART_keys !== 5'b00100) begin miscompares++; $display("FAIL ignore_keys: got %b expected 00100", SPART_keys); end
      vectors++; if (err_pulses !== e0) begin miscompares++; $display("FAIL ignore_err: got %0d pulses expected %0d", err_pulses, e0); end
   endtask

   task automatic test_frame_err;
      int e0, c0;
      logic [4:0] e, o;
      e0 = err_pulses;
      c0 = err_cycles;
      send_byte(8'h61, 1'b0, epar(8'h61));
      repeat (2 * CPB) @(negedge clk);
      vectors++; if (err_pulses !== e0 + 1) begin miscompares++; $display("FAIL stop_err_pulse: got %0d expected %0d", err_pulses, e0 + 1); end
      vectors++; if (err_cycles !== c0 + 1) begin miscompares++; $display("FAIL stop_err_width: got %0d expected %0d", err_cycles, c0 + 1); end
      vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL stop_err_strobe: got %0d strobes expected 0", obs_q.size()); end
      obs_q.delete();
      vectors++; if (SPART_keys !== 5'b00100) begin miscompares++; $display("FAIL stop_err_keys: got %b expected 00100", SPART_keys); end
      send_key(8'h61, 5'b00110);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 5'bxxxxx;
         vectors++; if (o !== e) begin miscompares++; $display("FAIL after_err: got %b expected %b", o, e); end
      end
      vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL after_err_extra: got %0d extra strobes expected 0", obs_q.size()); end
      obs_q.delete();
   endtask

   task automatic test_glitch;
      int  e0;
      logic busy_seen;
      e0 = err_pulses;
      busy_seen = 1'b0;
      rxd = 1'b0;
      repeat (3) @(negedge clk);
      rxd = 1'b1;
      for (int i = 0; i < 2 * CPB; i++) begin
         @(negedge clk);
         if (rx_busy === 1'b1) busy_seen = 1'b1;
      end
      vectors++; if (busy_seen !== 1'b1) begin miscompares++; $display("FAIL glitch_busy_seen: got %b expected 1", busy_seen); end
      vectors++; if (rx_busy !== 1'b0) begin miscompares++; $display("FAIL glitch_idle: got %b expected 0", rx_busy); end
      vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL glitch_strobe: got %0d strobes expected 0", obs_q.size()); end
      obs_q.delete();
      vectors++; if (err_pulses !== e0) begin miscompares++; $display("FAIL glitch_err: got %0d expected %0d", err_pulses, e0); end
      vectors++; if (SPART_keys !== 5'b00110) begin miscompares++; $display("FAIL glitch_keys: got %b expected 00110", SPART_keys); end
   endtask

   task automatic test_reset_midframe;
      logic [7:0] d;
      logic [4:0] e, o;
      d = 8'h77;
      rxd = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rxd = d[i];
         repeat (CPB) @(negedge clk);
      end
      rst_n = 1'b0;
      @(negedge clk);
      vectors++; if (SPART_keys !== 5'b00000) begin miscompares++; $display("FAIL mid_rst_keys: got %b expected 00000", SPART_keys); end
      vectors++; if (SPART_we !== 1'b0) begin miscompares++; $display("FAIL mid_rst_we: got %b expected 0", SPART_we); end
      vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL mid_rst_err: got %b expected 0", frame_err); end
      vectors++; if (rx_busy !== 1'b0) begin miscompares++; $display("FAIL mid_rst_busy: got %b expected 0", rx_busy); end
      rxd = 1'b1;
      repeat (4) @(negedge clk);
      rst_n = 1'b1;
      repeat (12 * CPB) @(negedge clk);
      vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL mid_rst_strobe: got %0d strobes expected 0", obs_q.size()); end
      obs_q.delete();
      vectors++; if (SPART_keys !== 5'b00000) begin miscompares++; $display("FAIL mid_rst_keys_after: got %b expected 00000", SPART_keys); end
      send_key(8'h61, 5'b00010);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 5'bxxxxx;
         vectors++; if (o !== e) begin miscompares++; $display("FAIL first_after_rst: got %b expected %b", o, e); end
      end
      vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL first_after_rst_extra: got %0d expected 0", obs_q.size()); end
      obs_q.delete();
   endtask

`ifdef SPART_PARITY_EN
   task automatic test_parity;
      int e0;
      logic [4:0] e, o;
      exp_q.push_back(5'b00110);
      send_byte(8'h73, 1'b1, 1'b1);
      while (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         if (obs_q.size() != 0) o = obs_q.pop_front(); else o = 5'bxxxxx;
         vectors++; if (o !== e) begin miscompares++; $display("FAIL parity_good: got %b expected %b", o, e); end
      end
      obs_q.delete();
      e0 = err_pulses;
      send_byte(8'h73, 1'b1, 1'b0);
      repeat (CPB) @(negedge clk);
      vectors++; if (err_pulses !== e0 + 1) begin miscompares++; $display("FAIL parity_bad_err: got %0d expected %0d", err_pulses, e0 + 1); end
      vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL parity_bad_strobe: got %0d expected 0", obs_q.size()); end
      obs_q.delete();
      vectors++; if (SPART_keys !== 5'b00110) begin miscompares++; $display("FAIL parity_bad_keys: got %b expected 00110", SPART_keys); end
   endtask
`endif

   task automatic test_invariants;
      vectors++; if (overlap_viol !== 0) begin miscompares++; $display("FAIL err_we_overlap: got %0d expected 0", overlap_viol); end
      vectors++; if (stable_viol !== 0) begin miscompares++; $display("FAIL keys_stability: got %0d changes expected 0", stable_viol); end
   endtask

   initial begin
      test_reset();
      test_set_keys();
      test_back_to_back();
      test_ignore();
      test_frame_err();
      test_glitch();
      test_reset_midframe();
`ifdef SPART_PARITY_EN
      test_parity();
`endif
      test_invariants();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
